// File: rtl/id_ex_reg.sv
// id_ex_reg: decode/execute pipeline register.
// Captures decode results every cycle and supports hold and flush from the pipeline controller.
// Detects load-use hazards against the instruction in decode. On a hazard it inserts one bubble
// and counts it in a saturating counter.
module id_ex_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic [31:0]      op1_i,
  input  logic [31:0]      op2_i,
  input  logic [31:0]      reg1_rdata_i,
  input  logic [31:0]      reg2_rdata_i,
  input  logic [4:0]       reg1_raddr_i,
  input  logic [4:0]       reg2_raddr_i,
  input  logic             reg_wen_i,
  input  logic [4:0]       reg_w_addr_i,
  input  logic             mem_ren_i,
  input  logic [31:0]      mem_raddr_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_addr_o,
  output logic [31:0]      op1_o,
  output logic [31:0]      op2_o,
  output logic [31:0]      reg1_rdata_o,
  output logic [31:0]      reg2_rdata_o,
  output logic             reg_wen_o,
  output logic [4:0]       reg_w_addr_o,
  output logic             mem_ren_o,
  output logic [31:0]      mem_raddr_o,
  output logic             valid_o,
  output logic             load_use_stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic rd_match;
  logic load_bubble;
  logic capture;
  logic count_bubble;

  // A resident load whose destination is a register that decode is reading now.
  // The destination must be nonzero, so x0 never stalls and a zero read index cannot match.
  assign rd_match = (reg_w_addr_o != 5'd0) &&
                    ((reg1_raddr_i == reg_w_addr_o) || (reg2_raddr_i == reg_w_addr_o));

  assign load_use_stall_o = valid_o & mem_ren_o & reg_wen_o & rd_match;

  // Update priority is rst > flush > hold > stall > capture. A stall under hold leaves the
  // load resident, so the request stays high until hold drops.
  assign load_bubble  = rst | flush_i | (~hold_i & load_use_stall_o);
  assign capture      = ~hold_i & ~load_use_stall_o;
  assign count_bubble = ~flush_i & ~hold_i & load_use_stall_o;

  // Pipeline payload: load a bubble, capture decode outputs, or keep the current contents.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (load_bubble) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= '0;
      op1_o        <= '0;
      op2_o        <= '0;
      reg1_rdata_o <= '0;
      reg2_rdata_o <= '0;
      reg_wen_o    <= 1'b0;
      reg_w_addr_o <= '0;
      mem_ren_o    <= 1'b0;
      mem_raddr_o  <= '0;
      valid_o      <= 1'b0;
    end else if (capture) begin
      inst_o       <= inst_i;
      inst_addr_o  <= inst_addr_i;
      op1_o        <= op1_i;
      op2_o        <= op2_i;
      reg1_rdata_o <= reg1_rdata_i;
      reg2_rdata_o <= reg2_rdata_i;
      reg_wen_o    <= reg_wen_i;
      reg_w_addr_o <= reg_w_addr_i;
      mem_ren_o    <= mem_ren_i;
      mem_raddr_o  <= mem_raddr_i;
      valid_o      <= 1'b1;
    end
  end

  // Saturating count of bubbles inserted for load-use hazards. Flush and hold suppress the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_o <= '0;
    end else if (count_bubble && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed and randomized checks of id_ex_reg against a behavioural model.
// Two instances share the stimulus: one uses the default counter width and one uses a 2-bit counter.
module tb_id_ex_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i, reg1_rdata_i, reg2_rdata_i, mem_raddr_i;
  logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_w_addr_i;
  logic        reg_wen_i, mem_ren_i, hold_i, flush_i;

  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, reg1_rdata_o, reg2_rdata_o, mem_raddr_o;
  logic        reg_wen_o, mem_ren_o, valid_o, load_use_stall_o;
  logic [4:0]  reg_w_addr_o;
  logic [15:0] bubble_cnt_o;

  logic [31:0] s_inst, s_inst_addr, s_op1, s_op2, s_r1, s_r2, s_maddr;
  logic        s_wen, s_ren, s_valid, s_stall;
  logic [4:0]  s_wa;
  logic [1:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_reg u_dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i),
    .op2_i(op2_i), .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .reg1_raddr_i(reg1_raddr_i), .reg2_raddr_i(reg2_raddr_i), .reg_wen_i(reg_wen_i),
    .reg_w_addr_i(reg_w_addr_i), .mem_ren_i(mem_ren_i), .mem_raddr_i(mem_raddr_i),
    .hold_i(hold_i), .flush_i(flush_i), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o), .reg1_rdata_o(reg1_rdata_o), .reg2_rdata_o(reg2_rdata_o),
    .reg_wen_o(reg_wen_o), .reg_w_addr_o(reg_w_addr_o), .mem_ren_o(mem_ren_o),
    .mem_raddr_o(mem_raddr_o), .valid_o(valid_o), .load_use_stall_o(load_use_stall_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_reg #(.CNT_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i),
    .op2_i(op2_i), .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .reg1_raddr_i(reg1_raddr_i), .reg2_raddr_i(reg2_raddr_i), .reg_wen_i(reg_wen_i),
    .reg_w_addr_i(reg_w_addr_i), .mem_ren_i(mem_ren_i), .mem_raddr_i(mem_raddr_i),
    .hold_i(hold_i), .flush_i(flush_i), .inst_o(s_inst), .inst_addr_o(s_inst_addr),
    .op1_o(s_op1), .op2_o(s_op2), .reg1_rdata_o(s_r1), .reg2_rdata_o(s_r2),
    .reg_wen_o(s_wen), .reg_w_addr_o(s_wa), .mem_ren_o(s_ren),
    .mem_raddr_o(s_maddr), .valid_o(s_valid), .load_use_stall_o(s_stall),
    .bubble_cnt_o(s_cnt)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] inst, pc, op1, op2, r1, r2, maddr;
    logic [4:0]  wa;
    logic        wen, ren, valid;
  } stage_t;

  stage_t m;
  int     cnt_big, cnt_small;
  bit     model_ok = 0;

  function automatic stage_t bubble();
    stage_t b;
    b.inst = NOP; b.pc = 0; b.op1 = 0; b.op2 = 0; b.r1 = 0; b.r2 = 0; b.maddr = 0;
    b.wa = 0; b.wen = 0; b.ren = 0; b.valid = 0;
    return b;
  endfunction

  // The resident instruction is a load of a real register that the decode instruction reads.
  function automatic bit hazard(stage_t s, logic [4:0] a1, logic [4:0] a2);
    return s.valid && s.ren && s.wen && (s.wa != 0) && (a1 == s.wa || a2 == s.wa);
  endfunction

  always @(posedge clk) begin
    bit stall;
    stall = hazard(m, reg1_raddr_i, reg2_raddr_i);
    if (rst) begin
      m = bubble(); cnt_big = 0; cnt_small = 0; model_ok = 1;
    end else if (flush_i) begin
      m = bubble();
    end else if (hold_i) begin
      m = m;
    end else if (stall) begin
      m = bubble();
      cnt_big   = (cnt_big   + 1 > 65535) ? 65535 : cnt_big + 1;
      cnt_small = (cnt_small + 1 > 3)     ? 3     : cnt_small + 1;
    end else begin
      m.inst = inst_i; m.pc = inst_addr_i; m.op1 = op1_i; m.op2 = op2_i;
      m.r1 = reg1_rdata_i; m.r2 = reg2_rdata_i; m.maddr = mem_raddr_i;
      m.wa = reg_w_addr_i; m.wen = reg_wen_i; m.ren = mem_ren_i; m.valid = 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    if (model_ok) begin
      check("m_inst",  inst_o, m.inst);
      check("m_pc",    inst_addr_o, m.pc);
      check("m_op1",   op1_o, m.op1);
      check("m_op2",   op2_o, m.op2);
      check("m_r1",    reg1_rdata_o, m.r1);
      check("m_r2",    reg2_rdata_o, m.r2);
      check("m_maddr", mem_raddr_o, m.maddr);
      check("m_ctrl",  {26'd0, reg_wen_o, mem_ren_o, valid_o, 3'd0},
                       {26'd0, m.wen, m.ren, m.valid, 3'd0});
      check("m_wa",    {27'd0, reg_w_addr_o}, {27'd0, m.wa});
      check("m_stall", {31'd0, load_use_stall_o},
                       {31'd0, hazard(m, reg1_raddr_i, reg2_raddr_i)});
      check("m_cnt",   {16'd0, bubble_cnt_o}, cnt_big);
      check("m_cnt_small", {30'd0, s_cnt}, cnt_small);
      check("m_small_inst", s_inst, m.inst);
      check("m_small_stall", {31'd0, s_stall}, {31'd0, load_use_stall_o});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_i = NOP; inst_addr_i = 0; op1_i = 0; op2_i = 0; reg1_rdata_i = 0; reg2_rdata_i = 0;
    reg1_raddr_i = 0; reg2_raddr_i = 0; reg_wen_i = 0; reg_w_addr_i = 0; mem_ren_i = 0;
    mem_raddr_i = 0; hold_i = 0; flush_i = 0;
  endtask

  task automatic set_load(input logic [31:0] inst, input logic [4:0] rd);
    clear_inputs();
    inst_i = inst; inst_addr_i = 32'h100; mem_ren_i = 1; reg_wen_i = 1;
    reg_w_addr_i = rd; mem_raddr_i = 32'h8000_0040;
  endtask

  task automatic set_use(input logic [31:0] inst, input logic [4:0] rs1, input logic [4:0] rs2);
    clear_inputs();
    inst_i = inst; inst_addr_i = 32'h104; reg_wen_i = 1; reg_w_addr_i = 5'd6;
    reg1_raddr_i = rs1; reg2_raddr_i = rs2;
  endtask

  initial begin
    // Reset with nonzero inputs present.
    rst = 1;
    clear_inputs();
    inst_i = 32'hdead_beef; inst_addr_i = 32'h44; op1_i = 1; reg_wen_i = 1; reg_w_addr_i = 3;
    mem_ren_i = 1; reg1_raddr_i = 3;
    tick(); tick();
    check("rst_inst", inst_o, NOP);
    check("rst_wen", {31'd0, reg_wen_o}, 0);
    check("rst_ren", {31'd0, mem_ren_o}, 0);
    check("rst_valid", {31'd0, valid_o}, 0);
    check("rst_cnt", {16'd0, bubble_cnt_o}, 0);

    // Pass-through.
    rst = 0;
    clear_inputs();
    inst_i = 32'h0050_0093; inst_addr_i = 32'h4; op1_i = 7; reg_wen_i = 1; reg_w_addr_i = 1;
    tick();
    check("pt_inst", inst_o, 32'h0050_0093);
    check("pt_pc", inst_addr_o, 32'h4);
    check("pt_op1", op1_o, 7);
    check("pt_wen", {31'd0, reg_wen_o}, 1);
    check("pt_wa", {27'd0, reg_w_addr_o}, 1);
    check("pt_valid", {31'd0, valid_o}, 1);

    // Load-use: one bubble, then the held decode instruction is captured.
    set_load(32'h0000_2283, 5'd5);
    tick();
    set_use(32'h0050_8333, 5'd1, 5'd5);
    #1 check("lu_stall", {31'd0, load_use_stall_o}, 1);
    tick();
    check("lu_bub_inst", inst_o, NOP);
    check("lu_bub_valid", {31'd0, valid_o}, 0);
    check("lu_cnt", {16'd0, bubble_cnt_o}, 1);
    check("lu_stall_drop", {31'd0, load_use_stall_o}, 0);
    tick();
    check("lu_capture", inst_o, 32'h0050_8333);
    check("lu_cap_valid", {31'd0, valid_o}, 1);

    // Hold for three cycles with changing inputs.
    clear_inputs();
    inst_i = 32'h0010_0113; inst_addr_i = 32'h40;
    tick();
    for (int i = 0; i < 3; i++) begin
      hold_i = 1; inst_i = 32'h1000 + i; inst_addr_i = 32'h80 + i;
      tick();
      check("hold_inst", inst_o, 32'h0010_0113);
      check("hold_pc", inst_addr_o, 32'h40);
    end
    // Hold together with flush: the bubble wins, the counter is unchanged.
    flush_i = 1;
    tick();
    check("hf_inst", inst_o, NOP);
    check("hf_valid", {31'd0, valid_o}, 0);
    check("hf_cnt", {16'd0, bubble_cnt_o}, 1);

    // Flush during an active stall.
    set_load(32'h0000_2283, 5'd5);
    tick();
    set_use(32'h0002_8433, 5'd5, 5'd0);
    flush_i = 1;
    #1 check("fs_stall", {31'd0, load_use_stall_o}, 1);
    tick();
    check("fs_inst", inst_o, NOP);
    check("fs_cnt", {16'd0, bubble_cnt_o}, 1);

    // Hold while a stall is pending: the load stays resident, no bubble until release.
    set_load(32'h0000_2383, 5'd7);
    tick();
    set_use(32'h0073_8533, 5'd0, 5'd7);
    hold_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hs_stall", {31'd0, load_use_stall_o}, 1);
      check("hs_inst", inst_o, 32'h0000_2383);
      check("hs_cnt", {16'd0, bubble_cnt_o}, 1);
    end
    hold_i = 0;
    tick();
    check("hs_rel_inst", inst_o, NOP);
    check("hs_rel_cnt", {16'd0, bubble_cnt_o}, 2);

    // x0 destination never stalls; a non-load never stalls.
    set_load(32'h0000_2003, 5'd0);
    tick();
    set_use(32'h0000_0033, 5'd0, 5'd0);
    reg_w_addr_i = 5'd5;
    #1 check("x0_stall", {31'd0, load_use_stall_o}, 0);
    tick();
    set_use(32'h0052_8033, 5'd5, 5'd0);
    #1 check("nonload_stall", {31'd0, load_use_stall_o}, 0);

    // Saturation: five stalls; the 2-bit counter reads 1, 2, 3, 3, 3.
    rst = 1;
    tick();
    rst = 0;
    set_load(32'h0052_a283, 5'd5);
    reg2_raddr_i = 5'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_stall", {31'd0, load_use_stall_o}, 1);
      tick();
      check("sat_small", {30'd0, s_cnt}, (i < 3) ? i + 1 : 3);
      check("sat_big", {16'd0, bubble_cnt_o}, i + 1);
    end

    // Randomized phase: small register indices make hazards frequent.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      hold_i       = ($urandom_range(0, 7) == 0);
      inst_i       = $urandom;
      inst_addr_i  = $urandom;
      op1_i        = $urandom;
      op2_i        = $urandom;
      reg1_rdata_i = $urandom;
      reg2_rdata_i = $urandom;
      mem_raddr_i  = $urandom;
      reg1_raddr_i = 5'($urandom_range(0, 7));
      reg2_raddr_i = 5'($urandom_range(0, 7));
      reg_w_addr_i = 5'($urandom_range(0, 7));
      reg_wen_i    = ($urandom_range(0, 3) != 0);
      mem_ren_i    = ($urandom_range(0, 1) != 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
